bin_to_bcd_serial: RTL and testbench

//  - Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock).
//  - Produces the four BCD digits that the BCD-to-7-segment decoder consumes, so counters and scores can be shown.
//  - Uses a start/done handshake and holds its result between conversions.

---
 rtl/bcd_pkg.sv | 26 ++
 rtl/bcd_add3_digit.sv | 11 +
 rtl/bin_to_bcd_serial.sv | 144 ++++++++++++++
 tb/tb_bin_to_bcd_serial.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared BCD constants, converter state type and blanking helper
package bcd_pkg;

    localparam int          BCD_DIGITS = 4;
    localparam logic [3:0]  BCD_BLANK  = 4'hF;
    localparam logic [13:0] BCD_MAX    = 14'd9999;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} bcd_conv_state_t;

    // Leading zeros become blanks from the thousands digit down; units always shown.
    function automatic logic [15:0] blank_leading_zeros(input logic [15:0] digits);
        logic [15:0] r;
        r = digits;
        if (digits[15:12] == 4'd0) begin
            r[15:12] = BCD_BLANK;
            if (digits[11:8] == 4'd0) begin
                r[11:8] = BCD_BLANK;
                if (digits[7:4] == 4'd0) begin
                    r[7:4] = BCD_BLANK;
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_add3_digit.sv
// rtl/bcd_add3_digit.sv - double-dabble nibble corrector, adds 3 when the digit is 5 or more
module bcd_add3_digit (
    input  logic [3:0] din,
    output logic [3:0] dout
);

    always_comb begin
        dout = (din >= 4'd5) ? (din + 4'd3) : din;
    end

endmodule

// File: rtl/bin_to_bcd_serial.sv
// rtl/bin_to_bcd_serial.sv - serial shift-and-add-3 binary to 4-digit BCD; BIN_TO_BCD_LZB_EN enables leading-zero blanking
module bin_to_bcd_serial #(
    parameter int BIN_W = 14
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [BIN_W-1:0] BIN,
    output logic             BUSY,
    output logic             DONE,
    output logic             OVERFLOW,
    output logic [3:0]       BCD_3,
    output logic [3:0]       BCD_2,
    output logic [3:0]       BCD_1,
    output logic [3:0]       BCD_0
);

    import bcd_pkg::BCD_DIGITS;
    import bcd_pkg::BCD_BLANK;
    import bcd_pkg::BCD_MAX;
    import bcd_pkg::bcd_conv_state_t;
    import bcd_pkg::IDLE;
    import bcd_pkg::SHIFT;
    import bcd_pkg::blank_leading_zeros;

    localparam int SR_W  = 16 + BIN_W;
    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(BIN_W - 1);

    bcd_conv_state_t  state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SR_W-1:0]  sr_q, sr_d;
    logic             ovf_pend_q, ovf_pend_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             ovf_q, ovf_d;
    logic [15:0]      bcd_q, bcd_d;

    logic [15:0]      corr;
    logic [SR_W-1:0]  corr_sr;
    logic [15:0]      result;
    logic             bin_ovf;
    logic             accept;

    genvar g;
    generate
        for (g = 0; g < BCD_DIGITS; g++) begin : g_add3
            bcd_add3_digit u_add3 (
                .din  (sr_q[BIN_W + 4*g +: 4]),
                .dout (corr[4*g +: 4])
            );
        end
        // Narrower inputs can never exceed 9999.
        if (BIN_W >= 14) begin : g_ovf
            assign bin_ovf = (BIN > BCD_MAX);
        end else begin : g_no_ovf
            assign bin_ovf = 1'b0;
        end
    endgenerate

    assign corr_sr = {corr, sr_q[BIN_W-1:0]};
    assign result  = sr_q[BIN_W +: 16];
    assign accept  = START && ((state_q == IDLE) || (state_q == bcd_pkg::DONE));

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sr_d       = sr_q;
        ovf_pend_d = ovf_pend_q;
        ovf_d      = ovf_q;
        bcd_d      = bcd_q;
        done_d     = 1'b0;

        case (state_q)
            IDLE: begin
                state_d = IDLE;
            end
            SHIFT: begin
                sr_d  = {corr_sr[SR_W-2:0], 1'b0};
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_SHIFT) begin
                    state_d = bcd_pkg::DONE;
                end
            end
            bcd_pkg::DONE: begin
                done_d  = 1'b1;
                ovf_d   = ovf_pend_q;
                state_d = IDLE;
                if (ovf_pend_q) begin
                    bcd_d = {BCD_BLANK, BCD_BLANK, BCD_BLANK, BCD_BLANK};
                end else begin
`ifdef BIN_TO_BCD_LZB_EN
                    bcd_d = blank_leading_zeros(result);
`else
                    bcd_d = result;
`endif
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (accept) begin
            state_d    = SHIFT;
            sr_d       = {16'd0, BIN};
            cnt_d      = '0;
            ovf_pend_d = bin_ovf;
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            sr_q       <= '0;
            ovf_pend_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
            bcd_q      <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sr_q       <= sr_d;
            ovf_pend_q <= ovf_pend_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            ovf_q      <= ovf_d;
            bcd_q      <= bcd_d;
        end
    end

    assign BUSY     = busy_q;
    assign DONE     = done_q;
    assign OVERFLOW = ovf_q;
    assign BCD_3    = bcd_q[15:12];
    assign BCD_2    = bcd_q[11:8];
    assign BCD_1    = bcd_q[7:4];
    assign BCD_0    = bcd_q[3:0];

endmodule

// File: tb/tb_bin_to_bcd_serial.sv
// tb/tb_bin_to_bcd_serial.sv - scoreboard bench for bin_to_bcd_serial (BIN_TO_BCD_LZB_EN aware)
module tb_bin_to_bcd_serial;

    localparam int BIN_W = 14;
`ifdef BIN_TO_BCD_LZB_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    logic             CLK = 1'b0;
    logic             RST;
    logic             START;
    logic [BIN_W-1:0] BIN;
    logic             BUSY;
    logic             DONE;
    logic             OVERFLOW;
    logic [3:0]       BCD_3, BCD_2, BCD_1, BCD_0;

    bin_to_bcd_serial #(.BIN_W(BIN_W)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .START    (START),
        .BIN      (BIN),
        .BUSY     (BUSY),
        .DONE     (DONE),
        .OVERFLOW (OVERFLOW),
        .BCD_3    (BCD_3),
        .BCD_2    (BCD_2),
        .BCD_1    (BCD_1),
        .BCD_0    (BCD_0)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [15:0] bcd;
        logic        ovf;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_bad = 0;
    time  t_acc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every DONE pulse must match the oldest outstanding expectation.
    always @(negedge CLK) begin
        if (DONE === 1'b1) begin
            if (q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_done: got DONE with bcd %h, expected no DONE",
                         {BCD_3, BCD_2, BCD_1, BCD_0});
            end else begin
                mon_e = q.pop_front();
                chk("bcd_digits", {16'd0, BCD_3, BCD_2, BCD_1, BCD_0}, {16'd0, mon_e.bcd});
                chk("overflow", {31'd0, OVERFLOW}, {31'd0, mon_e.ovf});
            end
        end
    end

    task automatic issue(input logic [BIN_W-1:0] bin, input logic [15:0] e,
                         input logic eo, input bit push);
        exp_t x;
        @(negedge CLK);
        START = 1'b1;
        BIN   = bin;
        @(posedge CLK);
        t_acc = $time;
        if (push) begin
            x.bcd = e;
            x.ovf = eo;
            q.push_back(x);
        end
        #1;
        START = 1'b0;
        BIN   = BIN_W'($urandom);
    endtask

    task automatic wait_done(output time td, output int busy_n);
        busy_n = 0;
        td     = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge CLK);
            if (DONE === 1'b1) begin
                td = $time;
                return;
            end
            if (BUSY === 1'b1) busy_n++;
        end
        n_cmp++;
        n_bad++;
        $display("FAIL done_timeout: got no DONE in 100 cycles, expected DONE");
    endtask

    function automatic logic [31:0] cycles_since(input time ta, input time td);
        return 32'((td - ta - 5) / 10);
    endfunction

    task automatic convert(input logic [BIN_W-1:0] bin, input logic [15:0] e, input logic eo);
        time td;
        int  bn;
        issue(bin, e, eo, 1'b1);
        wait_done(td, bn);
        chk("latency", cycles_since(t_acc, td), 32'd15);
        chk("busy_cycles", 32'(bn), 32'd15);
        chk("busy_at_done", {31'd0, BUSY}, 32'd0);
    endtask

    task automatic chk_outputs(input string name, input logic [15:0] e, input logic eo);
        chk(name, {15'd0, OVERFLOW, BCD_3, BCD_2, BCD_1, BCD_0}, {15'd0, eo, e});
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got simulation still running, expected finish");
        $fatal(1);
    end

    initial begin
        time ta1, ta2, td;
        int  bn;

        RST   = 1'b1;
        START = 1'b0;
        BIN   = '0;
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        chk_outputs("reset_outputs", 16'h0000, 1'b0);
        chk("reset_busy", {30'd0, BUSY, DONE}, 32'd0);

        // Basic conversion and latency.
        convert(14'd1234, 16'h1234, 1'b0);

        // Back-to-back: second START lands in the DONE-state cycle.
        issue(14'd9999, 16'h9999, 1'b0, 1'b1);
        ta1 = t_acc;
        repeat (14) @(negedge CLK);
        issue(14'd0, LZB ? 16'hFFF0 : 16'h0000, 1'b0, 1'b1);
        ta2 = t_acc;
        chk("b2b_accept_gap", cycles_since(ta1, ta2 + 5), 32'd15);
        wait_done(td, bn);
        chk("b2b_first_latency", cycles_since(ta1, td), 32'd15);
        chk("b2b_busy_kept", {31'd0, BUSY}, 32'd1);
        wait_done(td, bn);
        chk("b2b_second_latency", cycles_since(ta2, td), 32'd15);

        // Overflow boundary and recovery.
        convert(14'd10000, 16'hFFFF, 1'b1);
        convert(14'd5, LZB ? 16'hFFF5 : 16'h0005, 1'b0);
        repeat (3) @(negedge CLK);
        chk_outputs("hold_after_done", LZB ? 16'hFFF5 : 16'h0005, 1'b0);
        convert(14'd16383, 16'hFFFF, 1'b1);
        convert(14'd9, LZB ? 16'hFFF9 : 16'h0009, 1'b0);

        // START during SHIFT is ignored.
        issue(14'd321, LZB ? 16'hF321 : 16'h0321, 1'b0, 1'b1);
        repeat (5) @(negedge CLK);
        START = 1'b1;
        BIN   = 14'd7777;
        @(negedge CLK);
        START = 1'b0;
        wait_done(td, bn);
        chk("ignore_start_latency", cycles_since(t_acc, td), 32'd15);
        repeat (20) @(negedge CLK);

        // Reset at edge k+7 aborts the conversion.
        issue(14'd4321, 16'h4321, 1'b0, 1'b0);
        repeat (7) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        chk_outputs("abort_outputs", 16'h0000, 1'b0);
        chk("abort_busy", {30'd0, BUSY, DONE}, 32'd0);
        repeat (20) @(negedge CLK);
        convert(14'd5678, 16'h5678, 1'b0);

        // Blanking-sensitive vectors.
        convert(14'd42, LZB ? 16'hFF42 : 16'h0042, 1'b0);
        convert(14'd0, LZB ? 16'hFFF0 : 16'h0000, 1'b0);
        convert(14'd1005, 16'h1005, 1'b0);
        convert(14'd90, LZB ? 16'hFF90 : 16'h0090, 1'b0);

        repeat (5) @(negedge CLK);
        chk("queue_drained", 32'(q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
